// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 7-segment driver with frame-aligned double buffering,
// programmable polarity, decimal-point mask and leading-zero blanking.
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 100000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_blank,
    output logic [7:0]              cathode_array,
    output logic [NUM_DIGITS-1:0]   anode_array,
    output logic                    frame_done
);

    localparam int PRESC_W = $clog2(CLK_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRESC_W-1:0]    PRESC_MAX = PRESC_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic                  POL       = (ACTIVE_LOW != 0);
    localparam logic [7:0]            CATH_OFF  = {8{POL}};
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{POL}};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_to_seg = 7'h3F;
            4'h1:    hex_to_seg = 7'h06;
            4'h2:    hex_to_seg = 7'h5B;
            4'h3:    hex_to_seg = 7'h4F;
            4'h4:    hex_to_seg = 7'h66;
            4'h5:    hex_to_seg = 7'h6D;
            4'h6:    hex_to_seg = 7'h7D;
            4'h7:    hex_to_seg = 7'h07;
            4'h8:    hex_to_seg = 7'h7F;
            4'h9:    hex_to_seg = 7'h6F;
            4'hA:    hex_to_seg = 7'h77;
            4'hB:    hex_to_seg = 7'h7C;
            4'hC:    hex_to_seg = 7'h39;
            4'hD:    hex_to_seg = 7'h5E;
            4'hE:    hex_to_seg = 7'h79;
            4'hF:    hex_to_seg = 7'h71;
            default: hex_to_seg = 7'h00;
        endcase
    endfunction

    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic [7:0]            cathode_q, cathode_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;

    logic                  tick_s, wrap_s, zero_run_s, dp_sel_s, blank_sel_s;
    logic [3:0]            nib_sel_s;
    logic [6:0]            seg_on_s;
    logic [NUM_DIGITS-1:0] lz_mask_s, anode_on_s;

    assign tick_s = enable && (presc_q == PRESC_MAX);
    assign wrap_s = tick_s && (idx_q == IDX_MAX);

    // Scan counters, frame pulse and the pending/display double buffer.
    always_comb begin
        presc_d      = presc_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        if (enable) begin
            if (tick_s) begin
                presc_d = {PRESC_W{1'b0}};
                idx_d   = (idx_q == IDX_MAX) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
            frame_done_d = wrap_s;
        end else begin
            presc_d      = {PRESC_W{1'b0}};
            idx_d        = {IDX_W{1'b0}};
            frame_done_d = 1'b0;
        end
        // A load on the wrap tick bypasses pending, so any older pending value is dropped.
        if (wrap_s) begin
            pend_valid_d = 1'b0;
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_mask;
            end else if (pend_valid_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end else begin
                disp_val_d = disp_val_q;
                disp_dp_d  = disp_dp_q;
            end
        end else if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp_mask;
            pend_valid_d = 1'b1;
        end else begin
            pend_valid_d = pend_valid_q;
        end
    end

    // Digit selection, leading-zero detection and segment encoding.
    always_comb begin
        zero_run_s  = 1'b1;
        lz_mask_s   = {NUM_DIGITS{1'b0}};
        anode_on_s  = {NUM_DIGITS{1'b0}};
        nib_sel_s   = 4'h0;
        dp_sel_s    = 1'b0;
        blank_sel_s = 1'b0;
        seg_on_s    = 7'h00;
        cathode_d   = CATH_OFF;
        anode_d     = ANODE_OFF;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run_s   = zero_run_s && (disp_val_q[4*i +: 4] == 4'h0);
            lz_mask_s[i] = zero_run_s;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_sel_s     = disp_val_q[4*i +: 4];
                dp_sel_s      = disp_dp_q[i];
                blank_sel_s   = lz_mask_s[i];
                anode_on_s[i] = 1'b1;
            end else begin
                anode_on_s[i] = 1'b0;
            end
        end
        if (enable) begin
            seg_on_s  = (lz_blank && blank_sel_s) ? 7'h00 : hex_to_seg(nib_sel_s);
            cathode_d = {dp_sel_s, seg_on_s} ^ CATH_OFF;
            anode_d   = anode_on_s ^ ANODE_OFF;
        end else begin
            cathode_d = CATH_OFF;
            anode_d   = ANODE_OFF;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc_q      <= {PRESC_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            pend_val_q   <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_q    <= {NUM_DIGITS{1'b0}};
            pend_valid_q <= 1'b0;
            disp_val_q   <= {(4*NUM_DIGITS){1'b0}};
            disp_dp_q    <= {NUM_DIGITS{1'b0}};
            frame_done_q <= 1'b0;
            cathode_q    <= CATH_OFF;
            anode_q      <= ANODE_OFF;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            frame_done_q <= frame_done_d;
            cathode_q    <= cathode_d;
            anode_q      <= anode_d;
        end
    end

    assign cathode_array = cathode_q;
    assign anode_array   = anode_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: 4 digits, 4-cycle dwell, active-low.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        resetn, enable, load, lz_blank;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [7:0]  cathode_array;
    logic [3:0]  anode_array;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS(4),
        .CLK_DIV(4),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .enable(enable),
        .load(load),
        .value(value),
        .dp_mask(dp_mask),
        .lz_blank(lz_blank),
        .cathode_array(cathode_array),
        .anode_array(anode_array),
        .frame_done(frame_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] m);
        value   = v;
        dp_mask = m;
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    task automatic check_off(input string tag);
        check_val({tag, "_cath"}, {24'h0, cathode_array}, 32'hFF);
        check_val({tag, "_an"}, {28'h0, anode_array}, 32'hF);
        check_val({tag, "_fd"}, {31'h0, frame_done}, 32'h0);
    endtask

    // One full 16-cycle frame starting at digit 0; frame_done on the last cycle.
    task automatic check_frame(input string tag, input logic [7:0] c0, input logic [7:0] c1,
                               input logic [7:0] c2, input logic [7:0] c3);
        logic [7:0] exp_c [4];
        logic [3:0] exp_an;
        logic       exp_fd;
        exp_c = '{c0, c1, c2, c3};
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 4; k++) begin
                step();
                exp_an = 4'b0001 << d;
                exp_an = ~exp_an;
                exp_fd = (d == 3) && (k == 3);
                check_val({tag, "_an"}, {28'h0, anode_array}, {28'h0, exp_an});
                check_val({tag, "_cath"}, {24'h0, cathode_array}, {24'h0, exp_c[d]});
                check_val({tag, "_fd"}, {31'h0, frame_done}, {31'h0, exp_fd});
            end
        end
    endtask

    task automatic wait_frame(input string tag, input bit chk_zero);
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (frame_done) begin
                found = 1'b1;
                break;
            end else if (chk_zero) begin
                check_val({tag, "_hold"}, {24'h0, cathode_array}, 32'hC0);
            end
        end
        if (!found) begin
            check_val({tag, "_timeout"}, 32'h0, 32'h1);
        end
    endtask

    initial begin
        resetn   = 1'b0;
        enable   = 1'b1;
        load     = 1'b0;
        value    = 16'h0;
        dp_mask  = 4'h0;
        lz_blank = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step();
            check_off("t1_rst");
        end
        resetn = 1'b1;
        check_frame("t1_f0", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        check_frame("t1_f1", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        repeat (3) step();
        pulse_load(16'h1234, 4'h0);
        wait_frame("t2", 1'b1);
        check_frame("t2", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        repeat (3) step();
        pulse_load(16'hAAAA, 4'h0);
        repeat (11) step();
        pulse_load(16'h00F0, 4'b1000);
        check_val("t3_wrap_fd", {31'h0, frame_done}, 32'h1);
        check_frame("t3", 8'hC0, 8'h8E, 8'hC0, 8'h40);

        lz_blank = 1'b1;
        check_frame("t4", 8'hC0, 8'h8E, 8'hFF, 8'h7F);

        repeat (5) step();
        enable = 1'b0;
        pulse_load(16'h1234, 4'h0);
        check_off("t5_dis");
        for (int i = 0; i < 9; i++) begin
            step();
            check_off("t5_dis");
        end
        enable = 1'b1;
        check_frame("t5_a", 8'hC0, 8'h8E, 8'hFF, 8'h7F);
        check_frame("t5_b", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        lz_blank = 1'b0;
        repeat (3) step();
        pulse_load(16'h5678, 4'hF);
        repeat (2) step();
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_off("t6_rst");
        end
        resetn = 1'b1;
        check_frame("t6_a", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        check_frame("t6_b", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Parametrised, time-multiplexed 7-segment display driver for the PicoRV32 system top level; drives cathode_array and anode_array.
- The CPU side presents a packed hex value with a load strobe.
- The block double-buffers that value and commits it only at frame boundaries, so the display never tears.
- Adds a configurable digit count, configurable polarity, decimal-point mask and leading-zero blanking.

Parameters:
- NUM_DIGITS, 8: number of multiplexed digits (1..16).
- CLK_DIV, 100000: clk cycles each digit stays selected (>=2).
- ACTIVE_LOW, 1: 1 means segments and anodes are on when driven 0; 0 means on when driven 1.

Ports:
- clk  input  1  system clock.
- resetn  input  1  synchronous, active-low reset.
- enable  input  1  display enable; 0 blanks the display and holds the scan at reset state.
- load  input  1  single-cycle strobe that captures value and dp_mask into the pending buffer.
- value  input  4*NUM_DIGITS  hex nibbles; digit 0 is the least significant, at bits 3:0.
- dp_mask  input  NUM_DIGITS  decimal point on per digit.
- lz_blank  input  1  blank leading zero digits.
- cathode_array  output  8  bit7 = dp, bits6:0 = segments g..a.
- anode_array  output  NUM_DIGITS  one-hot digit select.
- frame_done  output  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0.

Behaviour:
- Reset (resetn=0 at posedge):
  - Prescaler = 0, digit_idx = 0, pending_valid = 0, pending and display registers = 0.
  - frame_done = 0.
  - All cathode and anode outputs at OFF level: all 1s if ACTIVE_LOW, else all 0s.
  - Reset mid-frame discards any pending load.
- Prescaler:
  - Counts 0..CLK_DIV-1 while enable=1.
  - On the cycle it equals CLK_DIV-1 (tick), it returns to 0 and digit_idx advances.
  - digit_idx wraps NUM_DIGITS-1 -> 0.
- frame_done: registered; asserted the cycle after a tick that wrapped digit_idx to 0.
- Commit, on the wrap tick:
  - If load=1 in the same cycle, the display register takes value/dp_mask directly (bypass).
  - Else if pending_valid=1, it takes pending; pending_valid clears.
  - Otherwise the display register is unchanged.
- load outside a wrap tick: pending <= value/dp_mask, pending_valid <= 1. Multiple loads within a frame: the last one wins.
- Outputs:
  - Registered. Cathode and anode in cycle n+1 reflect digit_idx and display in cycle n, so latency is 1 cycle.
  - The selected anode is ON; all others are OFF.
- Decode: hex 0-F to standard segments.
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Values are active-high a..g; invert when ACTIVE_LOW.
- dp (bit7): ON when dp_mask[digit_idx]=1. It is never affected by blanking.
- Leading-zero blank (lz_blank=1): digit i>0 has segments 6:0 OFF if all nibbles at index >= i are 0. Digit 0 is never blanked.
- enable=0:
  - Next cycle, all outputs go OFF.
  - Prescaler and digit_idx reset to 0; frame_done = 0.
  - Load and pending still operate, but no commit occurs.
  - When enable returns to 1, the scan restarts at digit 0.
- NUM_DIGITS=1: every tick is a wrap tick; frame_done pulses every CLK_DIV cycles.

Test Plan:
1. Reset and polarity check. ACTIVE_LOW=1, NUM_DIGITS=4, CLK_DIV=4. Hold resetn=0 for 5 cycles. -> cathode=FF and anode=F throughout. After release with enable=1: anode=E, then D, B, 7, each for 4 cycles; frame_done pulses once per 16 cycles.
2. Double-buffer. Pulse load with value=16'h1234 mid-frame. -> Digits keep showing 0 until the next wrap. The frame after shows digit0 cathode=~4F... precisely digit0='4' cathode=99, digit3='1' cathode=F9.
3. Bypass and last-load-wins. Load 16'hAAAA mid-frame, then load 16'h00F0 on the wrap-tick cycle. -> The next frame shows 00F0 and the pending AAAA is never displayed.
4. Leading-zero blank. Display 16'h00F0, lz_blank=1, dp_mask=4'b1000. -> digit3 cathode=7F (dp only), digit2=FF, digit1=8E ('F'), digit0=C0 ('0').
5. Enable gating. Drop enable mid-frame for 10 cycles. -> Next cycle cathode=FF and anode=F, no frame_done. On re-enable, anode=E (digit 0) for a full 4 cycles.
6. Reset mid-operation. Assert resetn=0 with pending_valid=1. -> Outputs go OFF; after release the display shows 0000 and the pending value is discarded.
